dma_fifo_sequencer: RTL
=======================

Name: dma_fifo_sequencer

Overview:
Store-and-forward copy engine that moves LEN 32-bit words from a source to a destination memory port through the team's 16-entry FIFO, which has 15 usable entries and a combinational read port. The block splits the transfer into bursts of at most BURST_MAX words, fills the FIFO from the read port, then drains it to the write port, and signals completion by interrupt. It sits between the register-mapped DMA configuration and the bus-side read/write channels; the FIFO is instantiated beside it, not inside it.

Parameters:
BURST_MAX, 8, maximum words per burst; legal range 1..15, bounded by FIFO usable depth.
LEN_W, 16, width of the transfer-length field, counted in words.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse; latches src/dst/len; honoured only in IDLE
abort  in  1  one-cycle pulse; cancels the transfer
src_addr  in  32  byte address of the source; word-aligned
dst_addr  in  32  byte address of the destination; word-aligned
len  in  LEN_W  number of words to copy
busy  out  1  high in any state other than IDLE
irq  out  1  sticky completion flag
irq_clr  in  1  clears irq
rd_req_valid  out  1  read-burst request
rd_req_ready  in  1  read-burst request accepted
rd_req_addr  out  32  read-burst start address
rd_req_len  out  4  beats in the read burst, minus 1
rd_valid  in  1  read data beat valid
rd_ready  out  1  read data beat accepted
rd_data  in  32  read data
fifo_wen  out  1  FIFO write enable
fifo_di  out  32  FIFO write data
fifo_ren  out  1  FIFO read enable
fifo_do  in  32  FIFO read data (combinational)
fifo_full  in  1  FIFO full flag
fifo_empty  in  1  FIFO empty flag
fifo_clear  out  1  synchronous FIFO clear
wr_req_valid  out  1  write-burst request
wr_req_ready  in  1  write-burst request accepted
wr_req_addr  out  32  write-burst start address
wr_req_len  out  4  beats in the write burst, minus 1
wr_valid  out  1  write data beat valid
wr_ready  in  1  write data beat accepted
wr_data  out  32  write data
wr_last  out  1  final beat of the write burst

Behaviour:
- Reset values: state IDLE; every output 0; internal address registers, remaining-length counter and beat counter 0.
- FSM states: IDLE, CLR, RD_REQ, RD_DATA, WR_REQ, WR_DATA, DONE.
- IDLE, start=1, len!=0: latch src, dst and remaining=len; go to CLR.
- IDLE, start=1, len=0: go to DONE; no bus traffic, no fifo_clear.
- start outside IDLE is ignored.
- CLR: fifo_clear=1 for exactly one cycle, then RD_REQ.
- Burst size: burst = min(remaining, BURST_MAX), registered when entering RD_REQ.
- RD_REQ: rd_req_valid=1, rd_req_addr=src, rd_req_len=burst-1. Address, length and valid are held stable until rd_req_ready. Handshake then goes to RD_DATA with beat=0.
- RD_DATA: rd_ready = ~fifo_full; fifo_wen = rd_valid & rd_ready; fifo_di = rd_data. Each accepted beat increments beat. Accepting beat burst-1 advances src by 4*burst and goes to WR_REQ.
- WR_REQ: wr_req_valid=1, wr_req_addr=dst, wr_req_len=burst-1, held stable until wr_req_ready. Handshake then goes to WR_DATA with beat=0.
- WR_DATA: wr_valid = ~fifo_empty; wr_data = fifo_do; fifo_ren = wr_valid & wr_ready; wr_last = (beat==burst-1) & wr_valid.
- Completing the last write beat: remaining -= burst and dst += 4*burst. Go to RD_REQ if remaining is still nonzero, else DONE.
- DONE: one cycle; irq set to 1; then IDLE.
- irq is sticky until irq_clr. If irq_clr and the set event occur in the same cycle, set wins.
- abort in any non-IDLE state: next state IDLE, fifo_clear pulses one cycle, irq not set, outstanding bus beats are dropped (rd_ready and wr_valid go low).
- abort and start in the same cycle while in IDLE: start is ignored.
- Address arithmetic is modulo 2^32; wrap is allowed and not flagged.
- len=1 gives a single 1-beat burst. A len that is not a multiple of BURST_MAX ends with a short burst.
- The FIFO never holds more than BURST_MAX words, so fifo_full is never hit with the default parameters. rd_ready gating on fifo_full is still mandatory.
- Latency: start to rd_req_valid is 2 cycles (IDLE→CLR→RD_REQ).
- rst asserted mid-transfer: immediate return to IDLE with all outputs 0. The FIFO is reset by the same rst.

Decomposition:
- Package dma_pkg holds:
  - a state enum type, dma_state_e, with the 7 states;
  - constants WORD_BYTES=4 and FIFO_USABLE=15;
  - a BURST_MAX legality check against FIFO_USABLE.
- One sub-module, dma_burst_calc: computes burst = min(remaining, BURST_MAX) and the 4*burst address increment.
- FSM and counters stay in the top module.

Test Plan:
- len=16, src=0x1000, dst=0x2000, BURST_MAX=8 → two read bursts at 0x1000/0x1008-word? no: at 0x1000 and 0x1020 with rd_req_len=7; write bursts at 0x2000 and 0x2020; data copied in order; irq=1 one cycle after the last wr beat.
- len=11 → bursts of 8 and 3 (rd_req_len 7 then 2); wr_last on beats 7 and 2 of each burst; remaining ends at 0.
- len=0 with start → DONE in 1 cycle; irq=1; no rd_req_valid or wr_req_valid ever asserted.
- Backpressure: rd_valid toggling every other cycle and wr_ready low for 5 cycles mid-burst → no lost or duplicated words; wr_data matches the source sequence.
- abort during WR_DATA of the first burst (len=16) → IDLE next cycle; fifo_clear pulse; busy=0; irq stays 0; a following start with len=4 completes correctly.
- rst asserted during RD_DATA → all outputs 0 immediately. start after deassertion runs a clean transfer. irq_clr in the same cycle as DONE leaves irq=1.

Source files
------------

// File: rtl/dma_pkg.sv
// dma_pkg: shared types and constants for the DMA FIFO sequencer.
//   dma_state_e     - sequencer FSM states
//   WORD_BYTES      - bytes per 32-bit transfer word
//   FIFO_USABLE     - usable entries of the companion 16-entry FIFO
//   burst_max_legal - checks a BURST_MAX choice against the FIFO depth
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLR     = 3'd1,
    RD_REQ  = 3'd2,
    RD_DATA = 3'd3,
    WR_REQ  = 3'd4,
    WR_DATA = 3'd5,
    DONE    = 3'd6
  } dma_state_e;

  localparam int unsigned WORD_BYTES  = 32'd4;
  localparam int unsigned FIFO_USABLE = 32'd15;

  // A burst must fit entirely in the FIFO, since it is filled before draining.
  function automatic bit burst_max_legal(input int unsigned burst_max);
    return (burst_max >= 32'd1) && (burst_max <= FIFO_USABLE);
  endfunction

endpackage

// File: rtl/dma_burst_calc.sv
// dma_burst_calc: burst sizing helper for the DMA FIFO sequencer.
//   remaining_i - words still to copy
//   cur_burst_i - burst size currently in flight
//   burst_o     - min(remaining_i, BURST_MAX), size of the next burst
//   incr_o      - byte address increment for the burst in flight
module dma_burst_calc
  import dma_pkg::*;
#(
  parameter int unsigned BURST_MAX = 8,
  parameter int unsigned LEN_W     = 16
) (
  input  logic [LEN_W-1:0] remaining_i,
  input  logic [3:0]       cur_burst_i,
  output logic [3:0]       burst_o,
  output logic [31:0]      incr_o
);

  localparam logic [LEN_W-1:0] BurstMaxLen = LEN_W'(BURST_MAX);
  localparam logic [3:0]       BurstMax4   = 4'(BURST_MAX);

  // Below BURST_MAX the remainder always fits in 4 bits.
  assign burst_o = (remaining_i >= BurstMaxLen) ? BurstMax4 : remaining_i[3:0];
  assign incr_o  = 32'(cur_burst_i) * 32'(WORD_BYTES);

endmodule

// File: rtl/dma_fifo_sequencer.sv
// dma_fifo_sequencer: store-and-forward copy engine. Splits a LEN-word copy
// into bursts of at most BURST_MAX words, fills the external FIFO from the
// read channel, drains it to the write channel, and raises a sticky irq.
//   clk, rst            - clock, asynchronous active-high reset
//   start/abort         - one-cycle control pulses
//   src_addr/dst_addr   - word-aligned byte addresses; len in words
//   busy, irq, irq_clr  - status and sticky completion interrupt
//   rd_req_*, rd_*      - read-burst request and read data channel
//   fifo_*              - external FIFO (combinational read port)
//   wr_req_*, wr_*      - write-burst request and write data channel
module dma_fifo_sequencer
  import dma_pkg::*;
#(
  parameter int unsigned BURST_MAX = 8,
  parameter int unsigned LEN_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             irq,
  input  logic             irq_clr,
  output logic             rd_req_valid,
  input  logic             rd_req_ready,
  output logic [31:0]      rd_req_addr,
  output logic [3:0]       rd_req_len,
  input  logic             rd_valid,
  output logic             rd_ready,
  input  logic [31:0]      rd_data,
  output logic             fifo_wen,
  output logic [31:0]      fifo_di,
  output logic             fifo_ren,
  input  logic [31:0]      fifo_do,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  output logic             fifo_clear,
  output logic             wr_req_valid,
  input  logic             wr_req_ready,
  output logic [31:0]      wr_req_addr,
  output logic [3:0]       wr_req_len,
  output logic             wr_valid,
  input  logic             wr_ready,
  output logic [31:0]      wr_data,
  output logic             wr_last
);

  if (!burst_max_legal(BURST_MAX)) begin : g_burst_max_check
    $error("dma_fifo_sequencer: BURST_MAX must lie in 1..FIFO_USABLE");
  end

  dma_state_e       state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [3:0]       beat_q, beat_d;
  logic [3:0]       burst_q, burst_d;
  logic             irq_q, irq_d;
  logic             fifo_clear_q, fifo_clear_d;

  logic [3:0]       calc_burst_s;
  logic [31:0]      incr_s;
  logic [3:0]       burst_last_s;
  logic             abort_s;
  logic             rd_ready_s;
  logic             rd_beat_s;
  logic             wr_valid_s;
  logic             wr_beat_s;
  logic             beat_end_s;
  logic             load_burst_s;

  // The next burst is sized from the post-update remaining count, so a burst
  // following a completed one already sees the decremented length.
  dma_burst_calc #(
    .BURST_MAX(BURST_MAX),
    .LEN_W    (LEN_W)
  ) u_burst_calc (
    .remaining_i(remaining_d),
    .cur_burst_i(burst_q),
    .burst_o    (calc_burst_s),
    .incr_o     (incr_s)
  );

  assign abort_s      = abort & (state_q != IDLE);
  assign burst_last_s = burst_q - 4'd1;
  assign beat_end_s   = (beat_q == burst_last_s);
  // Data beats are refused in the abort cycle so nothing half-lands.
  assign rd_ready_s   = (state_q == RD_DATA) & ~fifo_full & ~abort;
  assign rd_beat_s    = rd_ready_s & rd_valid;
  assign wr_valid_s   = (state_q == WR_DATA) & ~fifo_empty & ~abort;
  assign wr_beat_s    = wr_valid_s & wr_ready;

  assign load_burst_s = (state_d == RD_REQ) & (state_q != RD_REQ);
  assign burst_d      = load_burst_s ? calc_burst_s : burst_q;
  assign fifo_clear_d = (state_d == CLR) | abort_s;

  assign busy         = (state_q != IDLE);
  assign irq          = irq_q;
  assign rd_req_valid = (state_q == RD_REQ);
  assign rd_req_addr  = rd_req_valid ? src_q : 32'd0;
  assign rd_req_len   = rd_req_valid ? burst_last_s : 4'd0;
  assign rd_ready     = rd_ready_s;
  assign fifo_wen     = rd_beat_s;
  assign fifo_di      = (state_q == RD_DATA) ? rd_data : 32'd0;
  assign fifo_ren     = wr_beat_s;
  assign fifo_clear   = fifo_clear_q;
  assign wr_req_valid = (state_q == WR_REQ);
  assign wr_req_addr  = wr_req_valid ? dst_q : 32'd0;
  assign wr_req_len   = wr_req_valid ? burst_last_s : 4'd0;
  assign wr_valid     = wr_valid_s;
  assign wr_data      = (state_q == WR_DATA) ? fifo_do : 32'd0;
  assign wr_last      = beat_end_s & wr_valid_s;

  // Next-state, counter and interrupt logic.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    remaining_d = remaining_q;
    beat_d      = beat_q;
    irq_d       = irq_q & ~irq_clr;
    case (state_q)
      IDLE: begin
        if (start & ~abort) begin
          if (len != {LEN_W{1'b0}}) begin
            src_d       = src_addr;
            dst_d       = dst_addr;
            remaining_d = len;
            state_d     = CLR;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CLR: begin
        state_d = RD_REQ;
      end
      RD_REQ: begin
        if (rd_req_ready) begin
          beat_d  = 4'd0;
          state_d = RD_DATA;
        end else begin
          state_d = RD_REQ;
        end
      end
      RD_DATA: begin
        if (rd_beat_s) begin
          if (beat_end_s) begin
            src_d   = src_q + incr_s;
            beat_d  = 4'd0;
            state_d = WR_REQ;
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end else begin
          state_d = RD_DATA;
        end
      end
      WR_REQ: begin
        if (wr_req_ready) begin
          beat_d  = 4'd0;
          state_d = WR_DATA;
        end else begin
          state_d = WR_REQ;
        end
      end
      WR_DATA: begin
        if (wr_beat_s) begin
          if (beat_end_s) begin
            remaining_d = remaining_q - LEN_W'(burst_q);
            dst_d       = dst_q + incr_s;
            beat_d      = 4'd0;
            if (remaining_d != {LEN_W{1'b0}}) begin
              state_d = RD_REQ;
            end else begin
              state_d = DONE;
            end
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end else begin
          state_d = WR_DATA;
        end
      end
      DONE: begin
        irq_d   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Abort overrides everything, including the DONE irq set.
    if (abort_s) begin
      state_d = IDLE;
      beat_d  = 4'd0;
      irq_d   = irq_q & ~irq_clr;
    end else begin
      beat_d = beat_d;
    end
  end

  // State, address, counter and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      src_q        <= 32'd0;
      dst_q        <= 32'd0;
      remaining_q  <= {LEN_W{1'b0}};
      beat_q       <= 4'd0;
      burst_q      <= 4'd0;
      irq_q        <= 1'b0;
      fifo_clear_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      remaining_q  <= remaining_d;
      beat_q       <= beat_d;
      burst_q      <= burst_d;
      irq_q        <= irq_d;
      fifo_clear_q <= fifo_clear_d;
    end
  end

endmodule
